// File: rtl/up_sample_affine_ctrl.sv
// up_sample_affine_ctrl
//   Affine loop controller for a 3-deep iteration domain (EXT0 x EXT1 x EXT2).
//   After START_DELAY non-stalled cycles it presents one domain point every II
//   non-stalled cycles on en/ctrl_vars. It raises done once the last point has
//   been accepted.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous restart; has priority over stall and acceptance
//   stall      backpressure; freezes every counter and the state
//   en         a point is presented this cycle (buffer wen/ren)
//   ctrl_vars  loop indices; [0] outermost, [2] innermost (16 bit each)
//   done       whole domain accepted
module up_sample_affine_ctrl #(
  parameter int unsigned EXT0        = 1,
  parameter int unsigned EXT1        = 128,
  parameter int unsigned EXT2        = 128,
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned II          = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall,
  output logic             en,
  output logic [2:0][15:0] ctrl_vars,
  output logic             done
);

  localparam logic [15:0] E0M1 = 16'(EXT0 - 1);
  localparam logic [15:0] E1M1 = 16'(EXT1 - 1);
  localparam logic [15:0] E2M1 = 16'(EXT2 - 1);
  localparam logic [15:0] IIM1 = 16'(II - 1);
  localparam logic [15:0] SDLY = 16'(START_DELAY);

  typedef enum logic [1:0] {WAIT, RUN, DONE} state_t;

  state_t           state_q;
  logic [15:0]      dly_q;
  logic [15:0]      ii_q;
  logic [2:0][15:0] cv_q;
  logic             en_q;
  logic             done_q;

  logic [15:0] ii_d;
  logic        last_pt;

  always_comb begin
    ii_d    = (ii_q == IIM1) ? 16'd0 : ii_q + 16'd1;
    last_pt = (cv_q[0] == E0M1) && (cv_q[1] == E1M1) && (cv_q[2] == E2M1);
  end

  // en_q/done_q are written alongside the state so they always equal
  // (state==RUN && ii==0) and (state==DONE) without a combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      dly_q   <= '0;
      ii_q    <= '0;
      cv_q    <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (flush) begin
      state_q <= WAIT;
      dly_q   <= '0;
      ii_q    <= '0;
      cv_q    <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        WAIT: begin
          if (dly_q == SDLY) begin
            state_q <= RUN;
            ii_q    <= '0;
            en_q    <= 1'b1;
          end else begin
            dly_q <= dly_q + 16'd1;
          end
        end
        RUN: begin
          if (en_q && last_pt) begin
            // final point accepted: indices keep the last point
            state_q <= DONE;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ii_q <= ii_d;
            en_q <= (ii_d == 16'd0);
            if (en_q) begin
              if (cv_q[2] == E2M1) begin
                cv_q[2] <= '0;
                if (cv_q[1] == E1M1) begin
                  cv_q[1] <= '0;
                  cv_q[0] <= cv_q[0] + 16'd1;
                end else begin
                  cv_q[1] <= cv_q[1] + 16'd1;
                end
              end else begin
                cv_q[2] <= cv_q[2] + 16'd1;
              end
            end
          end
        end
        DONE: begin
          en_q   <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state_q <= WAIT;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign en        = en_q;
  assign ctrl_vars = cv_q;
  assign done      = done_q;

endmodule
